// File: rtl/ifetch_line_ctrl_pkg.sv
// fetch_pkg: shared state encoding, NOP constant and address-split width helpers
// for the single-line instruction-fetch controller.
package fetch_pkg;

  typedef enum logic {
    CHECK  = 1'b0,
    REFILL = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int unsigned idx_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Tag covers everything above the word index and the byte offset.
  function automatic int unsigned tag_width(input int unsigned data_w,
                                            input int unsigned line_words);
    return data_w - idx_width(line_words) - 2;
  endfunction

endpackage

// File: rtl/ifetch_line_ctrl_if.sv
// ifetch_mem_if: word-read request/ack bus between the fetch controller (master)
// and instruction memory (slave).
interface ifetch_mem_if #(
  parameter int dataW = 32
);
  logic             MemReq;
  logic [dataW-1:0] MemAddr;
  logic             MemAck;
  logic [31:0]      MemData;

  modport master (output MemReq, MemAddr, input  MemAck, MemData);
  modport slave  (input  MemReq, MemAddr, output MemAck, MemData);
endinterface

// File: rtl/ifetch_line_ctrl_store.sv
// ifetch_line_store: LINE_WORDS x 32 line buffer, one synchronous write port and
// one asynchronous read port, zeroed by reset.
module ifetch_line_store #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_data_o
);

  logic [31:0] mem_q [LINE_WORDS];

  // NOTE: resetting the array makes every word a reset flop, never a RAM macro;
  // acceptable for a handful of words and it keeps cold reads deterministic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LINE_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ifetch_line_ctrl.sv
// ifetch_line_ctrl: one-line instruction fetch buffer with word-by-word refill.
// Optional hit/miss performance counters are enabled by defining FETCH_PERF_CNT_EN.
module ifetch_line_ctrl
  import fetch_pkg::*;
#(
  parameter int dataW      = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic             InsCacheStall,
  ifetch_mem_if.master     mem
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      HitCount,
  output logic [31:0]      MissCount
`endif
);

  localparam int unsigned IDX   = idx_width(LINE_WORDS);
  localparam int unsigned TAG_W = tag_width(dataW, LINE_WORDS);

  fetch_state_e     state_q, state_d;
  logic [TAG_W-1:0] line_tag_q, line_tag_d;
  logic [TAG_W-1:0] fill_base_q, fill_base_d;
  logic             line_valid_q, line_valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic [IDX-1:0]   fill_cnt_q, fill_cnt_d;

  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [31:0]      rd_data;
  logic             wr_en;
  logic             hit;
  logic             unused_byte_ofs;

  assign rd_idx          = ProgAddr[IDX+1:2];
  assign fetch_tag       = ProgAddr[dataW-1:IDX+2];
  assign unused_byte_ofs = ^ProgAddr[1:0];

  // Flush forces a miss so the refill starts in the very cycle it is seen.
  assign hit = (state_q == CHECK) && line_valid_q && (fetch_tag == line_tag_q) && !Flush;

  ifetch_line_store #(
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .wr_en_i  (wr_en),
    .wr_idx_i (fill_cnt_q),
    .wr_data_i(mem.MemData),
    .rd_idx_i (rd_idx),
    .rd_data_o(rd_data)
  );

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    line_tag_d    = line_tag_q;
    line_valid_d  = line_valid_q;
    fill_base_d   = fill_base_q;
    fill_cnt_d    = fill_cnt_q;
    flush_pend_d  = flush_pend_q;
    wr_en         = 1'b0;
    Instr         = NOP;
    InstrValid    = 1'b0;
    InsCacheStall = 1'b1;
    mem.MemReq    = 1'b0;
    mem.MemAddr   = '0;

    unique case (state_q)
      CHECK: begin
        if (hit) begin
          Instr         = rd_data;
          InstrValid    = 1'b1;
          InsCacheStall = 1'b0;
        end else begin
          fill_base_d = fetch_tag;
          fill_cnt_d  = '0;
          state_d     = REFILL;
        end
        if (Flush) line_valid_d = 1'b0;
      end

      REFILL: begin
        mem.MemReq  = 1'b1;
        mem.MemAddr = {fill_base_q, fill_cnt_q, 2'b00};
        if (Flush) flush_pend_d = 1'b1;
        if (mem.MemAck) begin
          wr_en      = 1'b1;
          fill_cnt_d = fill_cnt_q + IDX'(1);
          if (fill_cnt_q == IDX'(LINE_WORDS - 1)) begin
            // A flush seen anywhere in the burst, including on the last ack,
            // leaves the freshly filled line unusable.
            line_tag_d   = fill_base_q;
            line_valid_d = !(flush_pend_q || Flush);
            flush_pend_d = 1'b0;
            state_d      = CHECK;
          end
        end
      end

      default: state_d = CHECK;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= CHECK;
      line_tag_q   <= '0;
      line_valid_q <= 1'b0;
      fill_base_q  <= '0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_tag_q   <= line_tag_d;
      line_valid_q <= line_valid_d;
      fill_base_q  <= fill_base_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == CHECK) && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_line_ctrl.sv
// Self-checking bench for ifetch_line_ctrl: directed scenarios with literal
// expectations plus a randomized run against a queue-based behavioural model.
module tb_ifetch_line_ctrl;

  localparam int          DW    = 32;
  localparam int          LW    = 4;
  localparam int          IDXB  = 2;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic [31:0] ProgAddr;
  logic        Flush;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InsCacheStall;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] HitCount;
  logic [31:0] MissCount;
`endif

  ifetch_mem_if #(.dataW(DW)) mem_bus ();

  ifetch_line_ctrl #(
    .dataW     (DW),
    .LINE_WORDS(LW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ProgAddr     (ProgAddr),
    .Flush        (Flush),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .InsCacheStall(InsCacheStall),
    .mem          (mem_bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .HitCount     (HitCount),
    .MissCount    (MissCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int salt);
    return 32'hC0DE_0000 ^ a ^ (32'(salt) << 24);
  endfunction

  // Behavioural model: line contents, tag, valid, and a queue of word addresses
  // still owed by the current refill (empty queue means the line is idle).
  logic [31:0] m_line [LW];
  logic [31:0] m_tag;
  logic        m_valid;
  logic        m_fp;
  logic [31:0] fill_q [$];
  int unsigned m_hits, m_misses;

  initial begin
    m_valid = 1'b0; m_tag = '0; m_fp = 1'b0; m_hits = 0; m_misses = 0;
    for (int i = 0; i < LW; i++) m_line[i] = '0;
    forever begin
      logic [31:0] a, tag, base;
      int          idx;
      logic        idle, e_hit;
      @(negedge clock);
      if (reset) begin
        m_valid = 1'b0; m_tag = '0; m_fp = 1'b0; m_hits = 0; m_misses = 0;
        fill_q.delete();
        for (int i = 0; i < LW; i++) m_line[i] = '0;
      end
      a     = ProgAddr;
      tag   = a >> (IDXB + 2);
      idx   = int'((a >> 2) % LW);
      idle  = (fill_q.size() == 0);
      e_hit = idle && m_valid && (tag == m_tag) && !Flush;

      check("m_instr",   Instr,             e_hit ? m_line[idx] : NOP_I);
      check("m_valid",   32'(InstrValid),    32'(e_hit));
      check("m_stall",   32'(InsCacheStall), 32'(!e_hit));
      check("m_memreq",  32'(mem_bus.MemReq), 32'(!idle));
      check("m_memaddr", mem_bus.MemAddr,    idle ? 32'h0 : fill_q[0]);
`ifdef FETCH_PERF_CNT_EN
      check("m_hitcnt",  HitCount,  m_hits);
      check("m_misscnt", MissCount, m_misses);
`endif

      if (!reset) begin
        if (idle) begin
          if (e_hit) m_hits++;
          else begin
            m_misses++;
            base = (a >> (IDXB + 2)) << (IDXB + 2);
            for (int i = 0; i < LW; i++) fill_q.push_back(base + 32'(4 * i));
          end
          if (Flush) m_valid = 1'b0;
        end else begin
          if (Flush) m_fp = 1'b1;
          if (mem_bus.MemAck) begin
            m_line[int'((fill_q[0] >> 2) % LW)] = mem_bus.MemData;
            m_tag = fill_q[0] >> (IDXB + 2);
            void'(fill_q.pop_front());
            if (fill_q.size() == 0) begin
              m_valid = !m_fp;
              m_fp    = 1'b0;
            end
          end
        end
      end
    end
  end

  logic [31:0] ack_addrs [$];

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Memory responder with a fixed number of wait cycles before each ack; returns
  // at the negedge of the first non-stalled cycle, or after a bounded budget.
  task automatic fill_run(input int waits, input int salt, output int stalls, output logic stable);
    int          wcnt;
    logic [31:0] paddr;
    logic        preq, pack;
    wcnt = 0; preq = 1'b0; pack = 1'b0; paddr = '0;
    stalls = 0; stable = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (mem_bus.MemReq) begin
        if (wcnt == waits) begin mem_bus.MemAck = 1'b1; wcnt = 0; end
        else begin mem_bus.MemAck = 1'b0; wcnt++; end
      end else mem_bus.MemAck = 1'b0;
      mem_bus.MemData = mem_word(mem_bus.MemAddr, salt);
      if (mem_bus.MemReq && preq && !pack && (mem_bus.MemAddr !== paddr)) stable = 1'b0;
      if (mem_bus.MemReq && mem_bus.MemAck) ack_addrs.push_back(mem_bus.MemAddr);
      preq = mem_bus.MemReq; pack = mem_bus.MemAck; paddr = mem_bus.MemAddr;
      @(negedge clock);
      if (!InsCacheStall) break;
      stalls++;
      next_cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   stalls;
    logic stable;
    int   hit_run;
    logic last_stall;
    logic [31:0] pc;

    reset = 1'b0; ProgAddr = '0; Flush = 1'b0;
    mem_bus.MemAck = 1'b0; mem_bus.MemData = '0;
    #2 reset = 1'b1;

    // Reset outputs.
    @(negedge clock);
    check("rst_stall",   32'(InsCacheStall),  32'd1);
    check("rst_valid",   32'(InstrValid),     32'd0);
    check("rst_instr",   Instr,               32'h0000_0013);
    check("rst_memreq",  32'(mem_bus.MemReq), 32'd0);
    check("rst_memaddr", mem_bus.MemAddr,     32'h0);
    @(posedge clock);
    #3 reset = 1'b0;

    // Cold start at address 0 with single-cycle acks.
    ack_addrs.delete();
    fill_run(0, 0, stalls, stable);
    check("cold_stalls", 32'(stalls), 32'd5);
    check("cold_addr0", ack_addrs.size() > 0 ? ack_addrs[0] : 32'hDEAD, 32'h0);
    check("cold_addr1", ack_addrs.size() > 1 ? ack_addrs[1] : 32'hDEAD, 32'h4);
    check("cold_addr2", ack_addrs.size() > 2 ? ack_addrs[2] : 32'hDEAD, 32'h8);
    check("cold_addr3", ack_addrs.size() > 3 ? ack_addrs[3] : 32'hDEAD, 32'hC);
    check("cold_valid", 32'(InstrValid), 32'd1);
    check("cold_instr", Instr, 32'hC0DE_0000);

    // Sequential hits through the rest of the line.
    for (int i = 1; i < 4; i++) begin
      next_cycle();
      ProgAddr = 32'(4 * i);
      @(negedge clock);
      check("seq_stall", 32'(InsCacheStall), 32'd0);
      check("seq_instr", Instr, 32'hC0DE_0000 | 32'(4 * i));
    end
    next_cycle();
    ProgAddr = 32'h10;
`ifdef FETCH_PERF_CNT_EN
    #1;
    check("perf_hits",   HitCount,  32'd4);
    check("perf_misses", MissCount, 32'd1);
`endif
    ack_addrs.delete();
    fill_run(0, 0, stalls, stable);
    check("next_line_addr", ack_addrs.size() > 0 ? ack_addrs[0] : 32'hDEAD, 32'h10);
    check("next_line_stalls", 32'(stalls), 32'd5);
    check("next_line_instr", Instr, 32'hC0DE_0010);

    // Two wait cycles before every ack.
    next_cycle();
    ProgAddr = 32'h40;
    fill_run(2, 0, stalls, stable);
    check("wait_stalls", 32'(stalls), 32'd13);
    check("wait_addr_stable", 32'(stable), 32'd1);
    check("wait_instr", Instr, 32'hC0DE_0040);

    // Flush during the third word of a burst.
    next_cycle();
    ProgAddr = 32'h80;
    for (int c = 0; c <= 10; c++) begin
      mem_bus.MemAck  = 1'b1;
      mem_bus.MemData = mem_word(mem_bus.MemAddr, (c >= 5) ? 2 : 1);
      Flush           = (c == 3);
      @(negedge clock);
      if (c == 5) begin
        check("flush_recheck_valid", 32'(InstrValid),    32'd0);
        check("flush_recheck_stall", 32'(InsCacheStall), 32'd1);
      end
      if (c == 6) check("flush_refetch_addr", mem_bus.MemAddr, 32'h80);
      if (c == 10) begin
        check("flush_final_valid", 32'(InstrValid), 32'd1);
        check("flush_final_instr", Instr, 32'hC2DE_0080);
      end
      if (c < 10) next_cycle();
    end
    Flush = 1'b0;

    // Reset in the middle of a burst, after two acks.
    next_cycle();
    ProgAddr = 32'hC0;
    for (int c = 0; c < 3; c++) begin
      mem_bus.MemAck  = 1'b1;
      mem_bus.MemData = mem_word(mem_bus.MemAddr, 9);
      next_cycle();
    end
    mem_bus.MemAck = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_memreq", 32'(mem_bus.MemReq), 32'd0);
    check("midrst_stall",  32'(InsCacheStall),  32'd1);
    check("midrst_valid",  32'(InstrValid),     32'd0);
    @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    check("postrst_memreq", 32'(mem_bus.MemReq), 32'd0);
    next_cycle();
    @(negedge clock);
    check("postrst_memaddr", mem_bus.MemAddr, 32'hC0);
    next_cycle();
    fill_run(0, 3, stalls, stable);
    check("postrst_instr", Instr, 32'hC3DE_00C0);

    // Randomized traffic: sequential fetch with jumps, flushes and random acks.
    pc = 32'h0; last_stall = 1'b0; hit_run = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      next_cycle();
      r = $urandom_range(0, 99);
      if (r < 8)        pc = 32'($urandom_range(0, 31)) << 2;
      else if (r < 10)  pc = $urandom & 32'hFFFF_FFFC;
      else if (!last_stall) pc = pc + 32'd4;
      ProgAddr        = pc | 32'($urandom_range(0, 3));
      Flush           = ($urandom_range(0, 29) == 0);
      mem_bus.MemAck  = ($urandom_range(0, 9) < 6);
      mem_bus.MemData = $urandom;
      @(negedge clock);
      last_stall = InsCacheStall;
      if (!InsCacheStall) hit_run++;
    end
    check("rand_saw_hits", 32'(hit_run > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_line_ctrl.md
# ifetch_line_ctrl

Instruction-fetch controller for the RV32I core. It sits between the program counter and instruction memory, and holds one instruction line of LINE_WORDS words. It returns instructions on a hit and runs a word-by-word refill burst on a miss. While the refill is in progress it stalls the PC through InsCacheStall.

## Interface
Parameters:
- dataW, 32, address/data width
- LINE_WORDS, 4, words per line; power of two, 2..16

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ProgAddr  in  dataW  fetch address from PC; bits [1:0] ignored
- Flush  in  1  invalidate line (fence.i / self-modifying code)
- Instr  out  32  fetched instruction
- InstrValid  out  1  Instr is valid this cycle
- InsCacheStall  out  1  PC hold request
- MemReq  out  1  memory word request
- MemAddr  out  dataW  word address of request, word aligned
- MemAck  in  1  memory returns MemData this cycle
- MemData  in  32  memory read data

## Operation
Address split:
- word index = ProgAddr[IDX+1:2], where IDX = log2(LINE_WORDS)
- tag = ProgAddr[dataW-1:IDX+2]
- state: line[LINE_WORDS], LineTag, LineValid, FillBase, FillCnt, FlushPend

Hit (combinational) = state CHECK && LineValid && tag == LineTag && !Flush.

CHECK state:
- On a hit: Instr = line[index], InstrValid = 1, InsCacheStall = 0.
- On a miss: InstrValid = 0, Instr = 32'h00000013 (NOP), InsCacheStall = 1.
  - Latch FillBase = {ProgAddr[dataW-1:IDX+2], 0}. Clear FillCnt. Go to REFILL.
- When Flush is asserted: clear LineValid at the clock edge. Flush counts as a miss, so the fill starts in the same cycle.

REFILL state:
- Outputs: MemReq = 1, MemAddr = FillBase + 4*FillCnt, InsCacheStall = 1, InstrValid = 0, Instr = NOP.
- On MemAck:
  - line[FillCnt] <= MemData, FillCnt++.
  - On the last word, set LineTag = FillBase tag and LineValid = !FlushPend, then go to CHECK.
- Flush asserted during REFILL sets FlushPend. The burst still completes, but the line is left invalid and a new miss follows. FlushPend clears on entry to CHECK.
- The fill uses FillBase only. A ProgAddr change during REFILL does not corrupt the fill and is resolved as hit or miss in CHECK.

Memory handshake:
- MemReq and MemAddr hold stable until MemAck.
- MemAck is ignored while MemReq = 0.
- Back-to-back acks (one word per cycle) are supported.

Reset (asynchronous):
- State goes to CHECK. LineValid, FlushPend, FillCnt, LineTag and line contents go to 0. MemReq goes to 0.
- Outputs during and after reset: InstrValid = 0, Instr = NOP, MemReq = 0, MemAddr = 0, InsCacheStall = 1, since LineValid = 0 forces a miss.
- Reset during REFILL abandons the burst. Memory must tolerate a dropped MemReq.

## Timing
- Hit: zero-cycle. Instr is combinational from ProgAddr, and the PC advances every cycle.
- Miss with single-cycle memory ack:
  - cycle 0: miss detected in CHECK, stall
  - cycles 1..LINE_WORDS: REFILL, one word per cycle
  - cycle LINE_WORDS+1: CHECK hit, stall low
  - Total stall is LINE_WORDS+1 cycles.
- Each memory wait cycle adds one stall cycle.
- InsCacheStall is combinational and reaches the PC in the cycle the miss is detected. The PC therefore never advances past an unfetched address.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs HitCount and MissCount, 32 bits each.
  - HitCount increments on each CHECK hit cycle; MissCount increments on each CHECK→REFILL transition.
  - Both wrap at 2^32 and reset to 0.
- FETCH_PERF_CNT_EN not defined: these ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package fetch_pkg holds:
  - state enum {CHECK, REFILL}
  - NOP constant 32'h00000013
  - index/tag width function of LINE_WORDS
- Sub-module ifetch_line_store: LINE_WORDS×32 register array with one write port (index, data, enable) and one asynchronous read port. It has no reset requirement beyond zeroing.

## Test plan
- Cold start, LINE_WORDS=4, ProgAddr=0, single-cycle acks:
  - stall is high for 5 cycles
  - MemAddr sequence is 0, 4, 8, 0xC
  - cycle 5: InstrValid = 1, Instr = word 0
- Sequential fetch 0→0xC after fill: 4 consecutive hits with no stall. At ProgAddr=0x10, a miss occurs and MemAddr = 0x10.
- Memory wait states, 2 idle cycles before each ack: MemAddr is held stable across the waits, and total stall is 4·3 + 1 = 13 cycles.
- Flush during REFILL at word 2: the burst completes with 4 acks, then a new miss refetches from the same FillBase. Data from the first burst is never presented as valid.
- Reset asserted mid-REFILL after 2 acks:
  - MemReq drops asynchronously and LineValid = 0.
  - After release, the refill restarts at the line base.
- With FETCH_PERF_CNT_EN: cold miss followed by 3 hits in the line gives MissCount = 1, HitCount = 4 (the post-fill cycle is counted as a hit).
